// File: rtl/gpu_pkg.sv
// Shared constants, state encoding and element addressing for the gpu_matmul engine.
package gpu_pkg;

    localparam int N     = 16;
    localparam int W     = 32;
    localparam int ELEMS = N * N;

    typedef logic [$clog2(N)-1:0]         idx_t;
    typedef logic [$clog2(ELEMS*W)-1:0]   bit_off_t;

    localparam idx_t LAST = idx_t'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Bit offset of element (r,c) in a row-major flat matrix bus.
    function automatic bit_off_t elem_off(input idx_t r, input idx_t c);
        return bit_off_t'((32'(r) * N + 32'(c)) * W);
    endfunction

endpackage

// File: rtl/gpu_mac_lane.sv
// One W-bit signed multiply-accumulate lane; the top instantiates one per output column.
module gpu_mac_lane
    import gpu_pkg::*;
(
    input  logic                CLK,
    input  logic                GPU_RES,
    input  logic                en,
    input  logic                clr,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum
);

    logic signed [W-1:0] prod;
    logic signed [W-1:0] acc_q;
    logic signed [W-1:0] acc_d;

    // Product and sum are truncated to W bits, giving modulo-2^W arithmetic.
    assign prod = a * b;
    assign sum  = acc_q + prod;

    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = clr ? '0 : sum;
        end
    end

    // NOTE: state registers use non-blocking assignments only; the next value is built in always_comb.
    always_ff @(posedge CLK or negedge GPU_RES) begin
        if (!GPU_RES) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/gpu_matmul.sv
// 16x16 signed integer matrix-multiply engine: N parallel MAC lanes, one row of C per N edges.
// Optional DONE output is enabled by defining GPU_DONE_EN.
module gpu_matmul
    import gpu_pkg::*;
(
    input  logic               CLK,
    input  logic               GPU_RES,
    input  logic               HLT,
    input  logic [ELEMS*W-1:0] input_matrix_A,
    input  logic [ELEMS*W-1:0] input_matrix_B,
    output logic [ELEMS*W-1:0] result_matrix
`ifdef GPU_DONE_EN
    ,
    output logic               DONE
`endif
);

    state_t             state_q, state_d;
    idx_t               i_q, i_d;
    idx_t               k_q, k_d;
    logic [ELEMS*W-1:0] result_q, result_d;

    logic               lane_en;
    logic               last_k;
    logic [W-1:0]       a_op;
    logic [W-1:0]       lane_sum [N];

    assign last_k = (k_q == LAST);
    assign a_op   = input_matrix_A[elem_off(i_q, k_q) +: W];

    for (genvar j = 0; j < N; j++) begin : g_lane
        gpu_mac_lane u_lane (
            .CLK     (CLK),
            .GPU_RES (GPU_RES),
            .en      (lane_en),
            .clr     (last_k),
            .a       (a_op),
            .b       (input_matrix_B[elem_off(k_q, idx_t'(j)) +: W]),
            .sum     (lane_sum[j])
        );
    end

`ifdef GPU_DONE_EN
    logic done_q, done_d;
`endif

    // NOTE: every signal written here gets its default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        k_d      = k_q;
        result_d = result_q;
        lane_en  = 1'b0;
`ifdef GPU_DONE_EN
        done_d   = done_q;
`endif
        if (!HLT) begin
            case (state_q)
                gpu_pkg::IDLE: state_d = gpu_pkg::RUN;
                gpu_pkg::RUN: begin
                    lane_en = 1'b1;
                    if (last_k) begin
                        // The lane sum already includes the k=N-1 term, so it is the finished element.
                        for (int j = 0; j < N; j++) begin
                            result_d[elem_off(i_q, idx_t'(j)) +: W] = lane_sum[j];
                        end
                        k_d = '0;
                        i_d = i_q + idx_t'(1);
                        if (i_q == LAST) begin
                            state_d = gpu_pkg::DONE;
`ifdef GPU_DONE_EN
                            done_d  = 1'b1;
`endif
                        end
                    end else begin
                        k_d = k_q + idx_t'(1);
                    end
                end
                gpu_pkg::DONE: state_d = gpu_pkg::DONE;
                default:       state_d = gpu_pkg::IDLE;
            endcase
        end
    end

    // NOTE: the result register is wide but must read as zero after reset, so it is reset like any control flop.
    always_ff @(posedge CLK or negedge GPU_RES) begin
        if (!GPU_RES) begin
            state_q  <= gpu_pkg::IDLE;
            i_q      <= '0;
            k_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            k_q      <= k_d;
            result_q <= result_d;
        end
    end

    assign result_matrix = result_q;

`ifdef GPU_DONE_EN
    always_ff @(posedge CLK or negedge GPU_RES) begin
        if (!GPU_RES) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign DONE = done_q;
`endif

endmodule

// File: tb/tb_gpu_matmul.sv
// Directed self-checking bench for gpu_matmul: identity, constants, signed/sparse, wrap, halt, mid-run reset.
module tb_gpu_matmul;

    localparam int N = 16;
    localparam int W = 32;

    logic                 CLK = 1'b0;
    logic                 GPU_RES = 1'b0;
    logic                 HLT = 1'b0;
    logic [N*N*W-1:0]     mat_a = '0;
    logic [N*N*W-1:0]     mat_b = '0;
    logic [N*N*W-1:0]     result_matrix;
`ifdef GPU_DONE_EN
    logic                 done;
`endif

    int n_checks = 0;
    int n_errors = 0;

    gpu_matmul dut (
        .CLK            (CLK),
        .GPU_RES        (GPU_RES),
        .HLT            (HLT),
        .input_matrix_A (mat_a),
        .input_matrix_B (mat_b),
        .result_matrix  (result_matrix)
`ifdef GPU_DONE_EN
        ,
        .DONE           (done)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] c_elem(input int r, input int c);
        return result_matrix[(r*N+c)*W +: W];
    endfunction

    task automatic set_a(input int r, input int c, input logic [W-1:0] v);
        mat_a[(r*N+c)*W +: W] = v;
    endtask

    task automatic set_b(input int r, input int c, input logic [W-1:0] v);
        mat_b[(r*N+c)*W +: W] = v;
    endtask

    // Hold reset for two cycles, release on a falling edge; the next rising edge is edge 1.
    task automatic start_run();
        GPU_RES = 1'b0;
        HLT     = 1'b0;
        repeat (2) @(negedge CLK);
        GPU_RES = 1'b1;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] exp);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                check($sformatf("%s C[%0d][%0d]", tag, r, c), c_elem(r, c), exp);
    endtask

    task automatic load_const();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                set_a(r, c, 32'd2);
                set_b(r, c, 32'd3);
            end
    endtask

    initial begin
        // Reset state: operands present, reset held, nothing may appear.
        load_const();
        repeat (4) @(negedge CLK);
        check("reset C[0][0]", c_elem(0, 0), 32'd0);
        check("reset C[15][15]", c_elem(15, 15), 32'd0);

        // Identity x B: result equals B.
        mat_a = '0;
        mat_b = '0;
        for (int r = 0; r < N; r++) begin
            set_a(r, r, 32'd1);
            for (int c = 0; c < N; c++) set_b(r, c, 32'(r*16 + c));
        end
        start_run();
        edges(257);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                check($sformatf("ident C[%0d][%0d]", r, c), c_elem(r, c), 32'(r*16 + c));

        // Constants: row 0 lands on edge 17, row 15 on edge 257.
        load_const();
        start_run();
        edges(16);
        check("const e16 C[0][5]", c_elem(0, 5), 32'd0);
        edges(1);
        check("const e17 C[0][5]", c_elem(0, 5), 32'd96);
        check("const e17 C[1][5]", c_elem(1, 5), 32'd0);
        edges(239);
        check("const e256 C[14][7]", c_elem(14, 7), 32'd96);
        check("const e256 C[15][3]", c_elem(15, 3), 32'd0);
`ifdef GPU_DONE_EN
        check("const e256 DONE", 32'(done), 32'd0);
`endif
        edges(1);
        check_all("const", 32'd96);
`ifdef GPU_DONE_EN
        check("const e257 DONE", 32'(done), 32'd1);
`endif
        edges(20);
        check("const hold C[15][15]", c_elem(15, 15), 32'd96);

        // Signed / sparse: C[0][0] = -4*1 + 12*23 = 272, C[4][0] = 4*1 = 4.
        mat_a = '0;
        mat_b = '0;
        set_a(0, 0, -32'sd4);
        set_a(4, 0, 32'd4);
        set_a(0, 1, 32'd12);
        set_b(0, 0, 32'd1);
        set_b(1, 0, 32'd23);
        start_run();
        edges(257);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                check($sformatf("sparse C[%0d][%0d]", r, c), c_elem(r, c),
                      (r == 0 && c == 0) ? 32'd272 : (r == 4 && c == 0) ? 32'd4 : 32'd0);

        // Wrap-around: 2^16 * 2^16 truncates to 0.
        mat_a = '0;
        mat_b = '0;
        set_a(0, 0, 32'h0001_0000);
        set_b(0, 0, 32'h0001_0000);
        start_run();
        edges(257);
        check("wrap16 C[0][0]", c_elem(0, 0), 32'h0000_0000);

        // Wrap-around: 0x7FFFFFFF * 2 = 0xFFFFFFFE.
        set_a(0, 0, 32'h7FFF_FFFF);
        set_b(0, 0, 32'd2);
        start_run();
        edges(257);
        check("wrapmax C[0][0]", c_elem(0, 0), 32'hFFFF_FFFE);
        check("wrapmax C[0][1]", c_elem(0, 1), 32'h0000_0000);

        // Halt for 37 edges after edge 50: rows 0..2 written, row 3 frozen, completion slips by 37.
        load_const();
        start_run();
        edges(50);
        @(negedge CLK);
        HLT = 1'b1;
        edges(37);
        check("halt C[2][0]", c_elem(2, 0), 32'd96);
        check("halt C[3][0]", c_elem(3, 0), 32'd0);
        @(negedge CLK);
        HLT = 1'b0;
        edges(206);
        check("halt e256 C[14][0]", c_elem(14, 0), 32'd96);
        check("halt e256 C[15][0]", c_elem(15, 0), 32'd0);
        edges(1);
        check_all("halt", 32'd96);

        // Reset mid-run at edge 100: rows 0..5 written, then cleared at once.
        start_run();
        edges(100);
        check("midrst pre C[5][0]", c_elem(5, 0), 32'd96);
        check("midrst pre C[6][0]", c_elem(6, 0), 32'd0);
        GPU_RES = 1'b0;
        #1;
        check("midrst C[0][0]", c_elem(0, 0), 32'd0);
        check("midrst C[5][15]", c_elem(5, 15), 32'd0);
        @(negedge CLK);
        GPU_RES = 1'b1;
        edges(256);
        check("midrst e256 C[15][9]", c_elem(15, 9), 32'd0);
        edges(1);
        check_all("midrst", 32'd96);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gpu_matmul.md
Name: gpu_matmul

Overview:
- Fixed-size integer matrix-multiply engine: computes result_matrix = A × B for two 16×16 signed 32-bit matrices presented on flat input buses.
- Sits as the compute core under a top-level or bench. Starts automatically after reset release and holds the finished product until the next reset.
- Internally uses 16 parallel MAC lanes, one per output column, which step through rows and inner index.

Parameters:
- N, 16, matrix dimension (square N×N).
- W, 32, element width in bits (signed two's complement).

Ports:
- CLK  input  1  rising-edge clock.
- GPU_RES  input  1  asynchronous, active-low reset.
- HLT  input  1  halt; high freezes all sequential state.
- input_matrix_A  input  N*N*W (8192)  matrix A, row-major; element (r,c) at bits [(r*N+c)*W +: W].
- input_matrix_B  input  N*N*W (8192)  matrix B, same packing.
- result_matrix  output  N*N*W (8192)  registered product C, same packing.

Behaviour:
- Reset (GPU_RES=0, asynchronous):
  - state=IDLE; row counter i=0; inner counter k=0.
  - All 16 lane accumulators = 0; result_matrix = all zeros.
- States:
  - IDLE: on the first rising edge after reset release with HLT=0, go to RUN.
  - RUN: each edge with HLT=0, every lane j does acc[j] += A[i][k]*B[k][j].
    - When k=15: write C[i][j] = acc[j] + A[i][15]*B[15][j] for all j; clear acc; k=0; i++.
    - When i=15 and k=15: final row written; go to DONE.
    - Otherwise k++.
  - DONE: terminal; result_matrix held; leaves only via reset.
- Latency: IDLE→RUN takes 1 edge, then 256 RUN edges. The full product is valid after the 257th non-halted rising edge following reset release.
- Rows are updated one at a time, at the RUN edges where k=15. Rows not yet written read as 0.
- Arithmetic:
  - Operands are signed W-bit.
  - Products and sums are kept modulo 2^W (low W bits), with no saturation and no overflow flag.
  - Accumulators are W bits.
- Inputs are sampled combinationally during RUN and are not latched. They must be stable from reset release until DONE. Changing them mid-run yields a mix of old and new operands; this is legal and undefined numerically.
- HLT=1: no register changes in any state, including partial accumulators. Resuming continues exactly where it stopped. HLT held in IDLE delays the start.
- Reset asserted mid-RUN: immediate return to IDLE with result cleared; the computation restarts after release.

Optional Feature:
- Macro GPU_DONE_EN.
- Defined: adds output port DONE (1 bit), registered, reset 0. It rises on the same edge the last row is written and stays 1 in DONE until reset.
- Undefined: no DONE port; completion is known only by cycle count (257 non-halted edges).

Decomposition:
- Shared package gpu_pkg:
  - Constants N=16 and W=32, plus derived ELEMS=N*N.
  - State enum {IDLE, RUN, DONE}.
  - Element-select helper, (r,c) → bit offset (r*N+c)*W.
- One natural sub-module, gpu_mac_lane: a single W-bit signed multiply-accumulate with clear and enable. It is instantiated N times, one per column.
- Control FSM, counters and result register stay in the top.

Test Plan:
- Identity × B: A = I (diagonal 1), B[r][c] = r*16+c; run 257 edges → result equals B element-for-element.
- Constants: A all 2, B all 3 → every C element = 96 (0x60) after 257 edges; before that, rows not yet written read 0.
- Signed/sparse: A[0][0] = −4, A[4][0] = 4, A[0][1] = 12, B[0][0] = 1, B[1][0] = 23, rest 0:
  - C[0][0] = 272 and C[4][0] = 4.
  - All other elements = 0.
- Wrap-around: A[0][0] = 0x00010000, B[0][0] = 0x00010000, rest 0 → C[0][0] = 0. With A[0][0] = 0x7FFFFFFF and B[0][0] = 2 → C[0][0] = 0xFFFFFFFE.
- Halt: constant test with HLT high for 37 edges mid-RUN → result identical, completion delayed by exactly 37 edges.
- Reset mid-run: assert GPU_RES low at edge 100 → result_matrix = 0 immediately. After release, the full correct result appears 257 edges later.
